// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b10
  } haz_state_e;

  // Stage-register control bundle, one field per output.
  typedef struct packed {
    logic pc_wr;
    logic pc_sel_br;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_wr;
    logic idex_bubble;
    logic exmem_wr;
    logic exmem_bubble;
  } haz_ctl_t;

  localparam haz_ctl_t CTL_RESET = '{pc_wr: 1'b0, pc_sel_br: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b1,
                                     idex_wr: 1'b0, idex_bubble: 1'b1, exmem_wr: 1'b0, exmem_bubble: 1'b1};
  localparam haz_ctl_t CTL_NORMAL = '{pc_wr: 1'b1, pc_sel_br: 1'b0, ifid_wr: 1'b1, ifid_flush: 1'b0,
                                      idex_wr: 1'b1, idex_bubble: 1'b0, exmem_wr: 1'b1, exmem_bubble: 1'b0};
  localparam haz_ctl_t CTL_FREEZE = '{pc_wr: 1'b0, pc_sel_br: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                      idex_wr: 1'b0, idex_bubble: 1'b0, exmem_wr: 1'b0, exmem_bubble: 1'b0};
  localparam haz_ctl_t CTL_BRANCH = '{pc_wr: 1'b1, pc_sel_br: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1,
                                      idex_wr: 1'b1, idex_bubble: 1'b1, exmem_wr: 1'b1, exmem_bubble: 1'b1};
  localparam haz_ctl_t CTL_LOADUSE = '{pc_wr: 1'b0, pc_sel_br: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                       idex_wr: 1'b1, idex_bubble: 1'b1, exmem_wr: 1'b1, exmem_bubble: 1'b0};

  // Saturating increment for the wait counter.
  function automatic logic [WCNT_W-1:0] sat_inc_wcnt(input logic [WCNT_W-1:0] v);
    return (v == '1) ? v : v + WCNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: EX load destination against the ID source registers, r0 excluded.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_MemtoReg,
  input  logic             ex_RegWr,
  output logic             load_use_c
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = (ex_rt == id_rs);
  assign rt_hit     = id_uses_rt & (ex_rt == id_rt);
  assign load_use_c = ex_MemtoReg & ex_RegWr & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch redirects (resolved in MEM) and
// data-memory busy freezes for the 5-stage CPU. Outputs are Mealy decodes.
// Optional feature macro: HAZ_STATS_EN adds stall_cnt / flush_cnt statistics outputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_MemtoReg,
  input  logic             ex_RegWr,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_wr,
  output logic             pc_sel_br,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_wr,
  output logic             idex_bubble,
  output logic             exmem_wr,
  output logic             exmem_bubble,
  output logic [1:0]       state,
  output logic             timeout_err
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Parameter sanity at elaboration.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("hazard_ctrl: MEM_TIMEOUT must be 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  haz_state_e        state_q, state_d;
  logic              br_pend_q, br_pend_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              load_use_c;
  logic              branch_c;
  haz_ctl_t          ctl_c;

  hazard_cmp u_cmp (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_MemtoReg (ex_MemtoReg),
    .ex_RegWr    (ex_RegWr),
    .load_use_c  (load_use_c)
  );

  assign branch_c = br_taken | br_pend_q;

  // State, pending branch, wait counter and sticky timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      br_pend_q  <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_pend_q  <= br_pend_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and Mealy output decode; a non-busy WAIT cycle behaves exactly like RUN.
  always_comb begin
    state_d    = state_q;
    br_pend_d  = br_pend_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctl_c      = CTL_NORMAL;

    if (mem_busy) begin
      ctl_c      = CTL_FREEZE;
      state_d    = ST_WAIT;
      wait_cnt_d = (state_q == ST_WAIT) ? sat_inc_wcnt(wait_cnt_q) : WCNT_W'(1);
      if (br_taken) begin
        br_pend_d = 1'b1;
      end
      if (wait_cnt_d == WCNT_W'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d    = ST_RUN;
      wait_cnt_d = '0;
      if (branch_c) begin
        ctl_c     = CTL_BRANCH;
        br_pend_d = 1'b0;
      end else if (load_use_c) begin
        ctl_c = CTL_LOADUSE;
      end
    end

    if (rst) begin
      ctl_c = CTL_RESET;
    end
  end

  assign pc_wr        = ctl_c.pc_wr;
  assign pc_sel_br    = ctl_c.pc_sel_br;
  assign ifid_wr      = ctl_c.ifid_wr;
  assign ifid_flush   = ctl_c.ifid_flush;
  assign idex_wr      = ctl_c.idex_wr;
  assign idex_bubble  = ctl_c.idex_bubble;
  assign exmem_wr     = ctl_c.exmem_wr;
  assign exmem_bubble = ctl_c.exmem_bubble;
  assign state        = state_q;
  assign timeout_err  = timeout_q;

`ifdef HAZ_STATS_EN
  logic stall_evt_c;
  logic flush_evt_c;

  assign stall_evt_c = mem_busy | (~branch_c & load_use_c);
  assign flush_evt_c = ~mem_busy & branch_c;

  // Saturating statistics counters for stall/freeze and branch-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt_c && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
